// File: rtl/cnot_unwind_engine.sv
// Reversible state engine: applies fan-out CNOTs to a state register, logs each op
// on a LIFO stack, and unwinds the most recent N ops on request.
module cnot_unwind_engine #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8,
   parameter int IDXW  = 2,
   parameter int CNTW  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [IDXW-1:0]  op_ctrl,
   input  logic [WIDTH-1:0] op_mask,
   input  logic             undo_req,
   input  logic [CNTW-1:0]  undo_count,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] state_out,
   output logic [CNTW-1:0]  depth,
   output logic             overflow
);
   localparam int PW = CNTW - 1;
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_UNWIND = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]       r_fsm;
   logic [WIDTH-1:0] r_state;
   logic [CNTW-1:0]  r_depth;
   logic [CNTW-1:0]  r_rem;
   logic             r_overflow;
   logic [IDXW-1:0]  r_stk_ctrl [DEPTH];
   logic [WIDTH-1:0] r_stk_mask [DEPTH];

   logic             w_full;
   logic [CNTW-1:0]  w_n;
   logic [PW-1:0]    w_push_idx;
   logic [PW-1:0]    w_pop_idx;
   logic [WIDTH-1:0] w_eff_mask;

   // The control bit is cleared from the mask, which makes every op self-inverse.
   function automatic logic [WIDTH-1:0] f_apply(input logic [WIDTH-1:0] s,
                                                input logic [IDXW-1:0]  c,
                                                input logic [WIDTH-1:0] m);
      logic [WIDTH-1:0] mm;
      mm    = m;
      mm[c] = 1'b0;
      return s ^ (mm & {WIDTH{s[c]}});
   endfunction

   assign w_full     = (r_depth == CNTW'(DEPTH));
   assign w_n        = (undo_count < r_depth) ? undo_count : r_depth;
   assign w_push_idx = r_depth[PW-1:0];
   assign w_pop_idx  = w_push_idx - PW'(1);

   always_comb begin
      w_eff_mask          = op_mask;
      w_eff_mask[op_ctrl] = 1'b0;
   end

   assign op_ready  = (r_fsm == S_IDLE) && !w_full && !load_valid && !undo_req;
   assign busy      = (r_fsm == S_UNWIND);
   assign done      = (r_fsm == S_DONE);
   assign state_out = r_state;
   assign depth     = r_depth;
   assign overflow  = r_overflow;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm      <= S_IDLE;
         r_state    <= '0;
         r_depth    <= '0;
         r_rem      <= '0;
         r_overflow <= 1'b0;
      end else begin
         case (r_fsm)
            S_IDLE: begin
               if (load_valid) begin
                  r_state <= load_data;
                  r_depth <= '0;
               end else if (undo_req) begin
                  r_rem <= w_n;
                  r_fsm <= (w_n == '0) ? S_DONE : S_UNWIND;
               end else if (op_valid) begin
                  if (w_full) begin
                     r_overflow <= 1'b1;
                  end else begin
                     r_state <= f_apply(r_state, op_ctrl, op_mask);
                     r_depth <= r_depth + CNTW'(1);
                  end
               end
            end
            S_UNWIND: begin
               r_state <= f_apply(r_state, r_stk_ctrl[w_pop_idx], r_stk_mask[w_pop_idx]);
               r_depth <= r_depth - CNTW'(1);
               r_rem   <= r_rem - CNTW'(1);
               if (r_rem == CNTW'(1)) r_fsm <= S_DONE;
            end
            S_DONE:  r_fsm <= S_IDLE;
            default: r_fsm <= S_IDLE;
         endcase
      end
   end

   // Stack storage needs no reset: entries above depth are never read.
   always_ff @(posedge clk) begin
      if (!rst && op_valid && op_ready) begin
         r_stk_ctrl[w_push_idx] <= op_ctrl;
         r_stk_mask[w_push_idx] <= w_eff_mask;
      end
   end
endmodule

// File: tb/tb_cnot_unwind_engine.sv
// Directed bench for cnot_unwind_engine: forward ops, unwind, clamp, overflow, reset.
module tb_cnot_unwind_engine;
   logic       clk = 1'b0;
   logic       rst;
   logic       load_valid;
   logic [3:0] load_data;
   logic       op_valid;
   logic       op_ready;
   logic [1:0] op_ctrl;
   logic [3:0] op_mask;
   logic       undo_req;
   logic [3:0] undo_count;
   logic       busy;
   logic       done;
   logic [3:0] state_out;
   logic [3:0] depth;
   logic       overflow;

   int n_cmp = 0;
   int n_bad = 0;

   cnot_unwind_engine #(.WIDTH(4), .DEPTH(8), .IDXW(2), .CNTW(4)) dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
      .op_valid(op_valid), .op_ready(op_ready), .op_ctrl(op_ctrl), .op_mask(op_mask),
      .undo_req(undo_req), .undo_count(undo_count), .busy(busy), .done(done),
      .state_out(state_out), .depth(depth), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [3:0] v);
      load_valid = 1'b1; load_data = v;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic do_op(input logic [1:0] c, input logic [3:0] m);
      op_valid = 1'b1; op_ctrl = c; op_mask = m;
      tick();
      op_valid = 1'b0;
   endtask

   task automatic start_undo(input logic [3:0] n);
      undo_req = 1'b1; undo_count = n;
      tick();
      undo_req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      n_cmp++; if (state_out !== 4'b0000) begin n_bad++; $display("FAIL reset_state got %b exp 0000", state_out); end
      n_cmp++; if (depth !== 4'd0) begin n_bad++; $display("FAIL reset_depth got %0d exp 0", depth); end
      n_cmp++; if ({busy, done, overflow} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b exp 000", {busy, done, overflow}); end
      n_cmp++; if (op_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b exp 1", op_ready); end
      load_valid = 1'b1; #1;
      n_cmp++; if (op_ready !== 1'b0) begin n_bad++; $display("FAIL ready_during_load got %b exp 0", op_ready); end
      load_valid = 1'b0;
   endtask

   task automatic test_basic();
      do_load(4'b0001);
      n_cmp++; if (state_out !== 4'b0001 || depth !== 4'd0) begin n_bad++; $display("FAIL basic_load got %b/%0d exp 0001/0", state_out, depth); end
      do_op(2'd0, 4'b1110);
      n_cmp++; if (state_out !== 4'b1111 || depth !== 4'd1) begin n_bad++; $display("FAIL basic_op got %b/%0d exp 1111/1", state_out, depth); end
      start_undo(4'd1);
      n_cmp++; if (busy !== 1'b1 || op_ready !== 1'b0) begin n_bad++; $display("FAIL basic_busy got %b/%b exp 1/0", busy, op_ready); end
      tick();
      n_cmp++; if (state_out !== 4'b0001 || depth !== 4'd0) begin n_bad++; $display("FAIL basic_undo got %b/%0d exp 0001/0", state_out, depth); end
      n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || op_ready !== 1'b0) begin n_bad++; $display("FAIL basic_done got d%b b%b r%b exp 1/0/0", done, busy, op_ready); end
      tick();
      n_cmp++; if (done !== 1'b0 || op_ready !== 1'b1) begin n_bad++; $display("FAIL basic_idle got d%b r%b exp 0/1", done, op_ready); end
   endtask

   task automatic test_sequence();
      logic [3:0] exp_fwd [3];
      logic [3:0] exp_bwd [3];
      exp_fwd = '{4'b1110, 4'b1111, 4'b1100};
      exp_bwd = '{4'b1111, 4'b1110, 4'b1010};
      do_load(4'b1010);
      do_op(2'd1, 4'b0100);
      n_cmp++; if (state_out !== exp_fwd[0]) begin n_bad++; $display("FAIL seq_fwd0 got %b exp %b", state_out, exp_fwd[0]); end
      do_op(2'd2, 4'b0001);
      n_cmp++; if (state_out !== exp_fwd[1]) begin n_bad++; $display("FAIL seq_fwd1 got %b exp %b", state_out, exp_fwd[1]); end
      do_op(2'd3, 4'b0011);
      n_cmp++; if (state_out !== exp_fwd[2] || depth !== 4'd3) begin n_bad++; $display("FAIL seq_fwd2 got %b/%0d exp %b/3", state_out, depth, exp_fwd[2]); end
      start_undo(4'd3);
      n_cmp++; if (busy !== 1'b1 || state_out !== 4'b1100) begin n_bad++; $display("FAIL seq_accept got b%b %b exp 1 1100", busy, state_out); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (state_out !== exp_bwd[i]) begin n_bad++; $display("FAIL seq_bwd%0d got %b exp %b", i, state_out, exp_bwd[i]); end
         n_cmp++; if (busy !== (i < 2) || done !== (i == 2)) begin n_bad++; $display("FAIL seq_flags%0d got b%b d%b exp b%b d%b", i, busy, done, i < 2, i == 2); end
      end
      n_cmp++; if (depth !== 4'd0) begin n_bad++; $display("FAIL seq_depth got %0d exp 0", depth); end
      tick();
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL seq_done_pulse got %b exp 0", done); end
   endtask

   task automatic test_ctrl_in_mask();
      do_load(4'b0001);
      do_op(2'd0, 4'b1111);
      n_cmp++; if (state_out !== 4'b1111) begin n_bad++; $display("FAIL ctrlmask got %b exp 1111", state_out); end
      start_undo(4'd1); tick();
      n_cmp++; if (state_out !== 4'b0001) begin n_bad++; $display("FAIL ctrlmask_undo got %b exp 0001", state_out); end
      tick();
   endtask

   task automatic test_overflow();
      do_load(4'b0001);
      for (int i = 0; i < 8; i++) do_op(2'd0, 4'b0010);
      n_cmp++; if (depth !== 4'd8 || state_out !== 4'b0001) begin n_bad++; $display("FAIL ovf_fill got %0d/%b exp 8/0001", depth, state_out); end
      n_cmp++; if (op_ready !== 1'b0 || overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_full got r%b o%b exp 0/0", op_ready, overflow); end
      do_op(2'd0, 4'b0100);
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b exp 1", overflow); end
      n_cmp++; if (state_out !== 4'b0001 || depth !== 4'd8) begin n_bad++; $display("FAIL ovf_drop got %b/%0d exp 0001/8", state_out, depth); end
   endtask

   task automatic test_clamp();
      int nbusy;
      do_load(4'b0001);
      do_op(2'd0, 4'b0010); do_op(2'd0, 4'b0100); do_op(2'd0, 4'b1000);
      n_cmp++; if (state_out !== 4'b1111 || overflow !== 1'b1) begin n_bad++; $display("FAIL clamp_setup got %b o%b exp 1111 o1", state_out, overflow); end
      start_undo(4'd15);
      nbusy = 0;
      for (int i = 0; i < 20 && done !== 1'b1; i++) begin
         if (busy === 1'b1) nbusy++;
         tick();
      end
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL clamp_timeout got done %b exp 1", done); end
      n_cmp++; if (nbusy != 3) begin n_bad++; $display("FAIL clamp_pops got %0d exp 3", nbusy); end
      n_cmp++; if (state_out !== 4'b0001 || depth !== 4'd0) begin n_bad++; $display("FAIL clamp_state got %b/%0d exp 0001/0", state_out, depth); end
      tick();
      do_op(2'd0, 4'b0010);
      start_undo(4'd0);
      n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL zero_done got d%b b%b exp 1/0", done, busy); end
      n_cmp++; if (state_out !== 4'b0011 || depth !== 4'd1) begin n_bad++; $display("FAIL zero_state got %b/%0d exp 0011/1", state_out, depth); end
      tick();
   endtask

   task automatic test_reset_mid_unwind();
      do_load(4'b0001);
      do_op(2'd0, 4'b0010); do_op(2'd0, 4'b0100); do_op(2'd0, 4'b1000);
      do_op(2'd0, 4'b0010); do_op(2'd0, 4'b0100);
      n_cmp++; if (state_out !== 4'b1001 || depth !== 4'd5) begin n_bad++; $display("FAIL mid_setup got %b/%0d exp 1001/5", state_out, depth); end
      start_undo(4'd5); tick(); tick();
      n_cmp++; if (state_out !== 4'b1111 || depth !== 4'd3 || busy !== 1'b1) begin n_bad++; $display("FAIL mid_partial got %b/%0d b%b exp 1111/3 b1", state_out, depth, busy); end
      rst = 1'b1; tick(); rst = 1'b0;
      n_cmp++; if (state_out !== 4'b0000 || depth !== 4'd0) begin n_bad++; $display("FAIL mid_rst got %b/%0d exp 0000/0", state_out, depth); end
      n_cmp++; if ({busy, done, overflow} !== 3'b000 || op_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_flags got %b r%b exp 000 r1", {busy, done, overflow}, op_ready); end
      tick();
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_no_done got d%b b%b exp 0/0", done, busy); end
   endtask

   initial begin
      rst = 1'b1; load_valid = 1'b0; load_data = '0; op_valid = 1'b0;
      op_ctrl = '0; op_mask = '0; undo_req = 1'b0; undo_count = '0;
      test_reset();
      test_basic();
      test_sequence();
      test_ctrl_in_mask();
      test_overflow();
      test_clamp();
      test_reset_mid_unwind();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cnot_unwind_engine.md
Name: cnot_unwind_engine

Overview:
- Sequential register-state engine for the reversible datapath: applies fan-out controlled-NOT operations (one control bit, multiple targets) to a WIDTH-bit state register.
- Records every applied operation on a LIFO history stack.
- On request, unwinds (uncomputes) the last N operations in reverse order. Each CNOT fan-out is self-inverse, so re-applying a popped op restores the prior state.
- This is the reverse-direction counterpart to the forward CNOT fan-out gates. It is used to clear ancilla/garbage bits after a computation.

Parameters:
- WIDTH, 4, state register width in bits.
- DEPTH, 8, history stack entries; a power of 2, at least 2.
- IDXW, 2, control index width; must equal clog2(WIDTH).
- CNTW, 4, undo_count/depth width; must equal clog2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- load_valid  input  1  load new state, clear history (IDLE only)
- load_data  input  WIDTH  value loaded into state
- op_valid  input  1  forward op offered
- op_ready  output  1  engine can accept forward op this cycle
- op_ctrl  input  IDXW  control bit index
- op_mask  input  WIDTH  target bit mask
- undo_req  input  1  start unwind (IDLE only, single-cycle sample)
- undo_count  input  CNTW  number of ops to unwind
- busy  output  1  high in UNWIND
- done  output  1  one-cycle pulse when unwind completes
- state_out  output  WIDTH  current state register
- depth  output  CNTW  number of ops on stack
- overflow  output  1  sticky: op_valid seen while stack full in IDLE

Behaviour:
- Reset (rst=1 at posedge) sets: state_out=0, depth=0, FSM=IDLE, busy=0, done=0, overflow=0. Reset applies in any state, including mid-UNWIND; the partially unwound state is discarded.
- Op effect: effective mask m = op_mask with bit op_ctrl forced to 0. Then new_state[i] = state[i] ^ (m[i] & state[op_ctrl]). The control bit is never modified.
- FSM states: IDLE, UNWIND, DONE.
- op_ready = (FSM==IDLE) && (depth<DEPTH) && !load_valid && !undo_req.
- IDLE priority, sampled each posedge: load_valid > undo_req > op_valid.
- load_valid: state<=load_data, depth<=0. No op is pushed.
- undo_req: N = min(undo_count, depth) is latched into a remaining-count register; FSM->UNWIND. If N==0, FSM->DONE directly.
- op_valid with op_ready: state updated and {op_ctrl, m} pushed, depth+1. The new state is visible on state_out the next cycle (1-cycle latency).
- op_valid while depth==DEPTH in IDLE, with no higher-priority request: op dropped and overflow<=1. overflow is cleared only by rst.
- UNWIND: each cycle, pop the top entry, apply the op to state, decrement depth and remaining. When remaining reaches 0 after a pop, FSM->DONE.
- Unwind timing: N pops take exactly N cycles. After undo_req is accepted at edge k, the pops occur at edges k+1..k+N.
- In UNWIND, load_valid, op_valid and undo_req are ignored; op_ready=0.
- DONE: lasts one cycle with done=1, busy=0, op_ready=0. Then FSM->IDLE.
- Stack is a LIFO with a pointer equal to depth. A pop never underflows, because N is clamped.
- All outputs are registered except op_ready.

Test Plan:
- Reset, load 4'b0001, op ctrl=0 mask=4'b1110 -> next cycle state_out=4'b1111, depth=1. Undo 1 -> after 1 UNWIND cycle state_out=4'b0001, depth=0, done pulse.
- Load 4'b1010. Ops (ctrl=1, mask=0100), then (ctrl=2, mask=0001), then (ctrl=3, mask=0011) -> states 1110, 1111, 1100. Undo 3 -> states 1111, 1110, 1010 on consecutive cycles; busy high 3 cycles; done 1 cycle.
- Op with mask bit at ctrl set (ctrl=0, mask=1111, state 0001) -> state 1111; bit0 unchanged.
- Push 8 ops -> depth=8, op_ready=0. A 9th op_valid -> dropped, overflow=1, state unchanged.
- undo_count=15 with depth=3 -> exactly 3 pops. undo_count=0 -> done next cycle, state unchanged.
- rst asserted mid-UNWIND (after 2 of 5 pops) -> next cycle state_out=0, depth=0, IDLE, overflow=0, no done pulse.
